pillar_pass_scorer: RTL
=======================

Name: pillar_pass_scorer

Overview:
- Parametrised successor to the fixed 3-pillar, 2-digit scoreboard.
- Watches N_PILLARS pillar channels and credits exactly one point per pillar the bird clears inside its gap.
- Keeps a DIGITS-wide BCD score and drives active-low seven-segment codes for the HEX displays.
- Sits between the pillar/bird position generators and the display layer, alongside collision detection.

Parameters:
- N_PILLARS, 3, number of pillar channels.
- DIGITS, 2, BCD score digits.
- X_W, 8, pillar x-coordinate width.
- Y_W, 7, bird/gap y-coordinate width.
- PASS_X, 14, x-coordinate at which a pillar counts as passed.
- GAP_H, 36, gap height in pixels.

Ports:
- clk  in  1  clock
- reset_n  in  1  full reset
- game_reset  in  1  active-low, clears current game score
- enable  in  1  frame tick; detection qualifier
- pillar_x  in  N_PILLARS*X_W  packed pillar x; channel i at [i*X_W +: X_W]
- gap_y  in  N_PILLARS*Y_W  packed gap top y; channel i at [i*Y_W +: Y_W]
- bird_y  in  Y_W  bird y
- score_bcd  out  4*DIGITS  BCD score; digit 0 (units) in bits [3:0]
- seg  out  7*DIGITS  active-low seven-segment codes; digit k at [k*7 +: 7]
- score_pulse  out  1  one-cycle pulse when score increments
- saturated  out  1  score has reached all 9s

Behaviour:
- Reset is decided: reset_n, synchronous, active-low; clock clk.
- reset_n low:
  - score_bcd = 0, pending = 0, armed = all 1, score_pulse = 0, saturated = 0.
  - best_bcd = 0 when BEST_SCORE_EN is defined.
- game_reset low (reset_n high): same clears as reset_n, except best_bcd is retained. This overrides all other activity that cycle.
- In-gap test per channel, evaluated at Y_W+1 bits so it cannot wrap: gap_y[i] < bird_y AND bird_y <= gap_y[i] + GAP_H.
- Per-channel armed flag:
  - Cleared on the edge where pillar_x[i] == PASS_X.
  - Set on any edge where pillar_x[i] != PASS_X.
  - Result: a pillar that dwells at PASS_X for many cycles is credited once.
- Detection: at edge T, if enable AND armed[i] AND pillar_x[i] == PASS_X AND in-gap(i), then pending[i] <= 1.
  - armed[i] clears at T whether or not the bird is in the gap; a missed pillar earns nothing.
- Service:
  - Each edge, the lowest-index set pending bit is cleared and the score incremented. At most one increment per cycle.
  - Latency: detection at edge T gives score update and score_pulse high after edge T+1.
  - Simultaneous passes on k channels are credited on k consecutive cycles, lowest index first.
  - New detections in a service cycle are OR-ed into pending. The same bit cannot be set and cleared in one cycle because armed blocks re-detection.
- BCD increment:
  - A digit equal to 9 becomes 0 and carries; otherwise it increments and the carry stops.
  - If all digits are 9: score holds, saturated = 1, score_pulse = 0, and the pending bit is still cleared.
- saturated is registered and stays high until reset_n or game_reset.
- seg is combinational from score_bcd. Bit 6 = a … bit 0 = g, active-low:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0001100
  - Any non-BCD nibble = 1111111 (blank).
- enable low: no new detections, but pending service continues and armed tracking continues.

Optional Feature:
- Macro BEST_SCORE_EN.
- Defined:
  - Adds output best_bcd (4*DIGITS) and seg_best (7*DIGITS, same encoding as seg).
  - On every score increment where the pre-increment score == best_bcd, best_bcd takes the new score on the same edge.
  - Score is monotonic between game resets, so best_bcd never drops.
  - best_bcd survives game_reset; it clears only on reset_n.
- Undefined: these ports and the register do not exist; all other behaviour is identical.

Test Plan:
- Reset, then pillar 0 at x=14 for 5 enabled cycles, gap_y=20, bird_y=40 -> score_bcd=0x01, one score_pulse, 2 cycles after first match.
- Pillar 1 at x=14, gap_y=20, bird_y=20 (boundary, not in gap) -> no increment. Repeat with bird_y=56 -> +1; bird_y=57 -> none.
- Pillars 0 and 2 both at x=14, in gap, same cycle -> score +1 on two consecutive cycles, two pulses.
- Preload score to 09 via passes, one more pass -> score_bcd=0x10, seg digit0=0000001, digit1=1001111. At 99, pass -> stays 0x99, saturated=1, no pulse.
- Score 05, pulse game_reset low one cycle -> score 0, pending cleared, saturated 0. With BEST_SCORE_EN: best_bcd stays 0x05; reach 06 -> best 0x06.
- Pending detection, then reset_n low the next cycle -> no increment, all outputs 0.

Source files
------------

// File: rtl/pillar_pass_scorer_if.sv
// Bundle of the pillar/bird inputs and score/display outputs of the pillar
// pass scorer. The best-score outputs exist only when BEST_SCORE_EN is defined.
interface pillar_pass_scorer_if #(
    parameter int N_PILLARS = 3,
    parameter int DIGITS    = 2,
    parameter int X_W       = 8,
    parameter int Y_W       = 7
);
    logic                      game_reset;
    logic                      enable;
    logic [N_PILLARS*X_W-1:0]  pillar_x;
    logic [N_PILLARS*Y_W-1:0]  gap_y;
    logic [Y_W-1:0]            bird_y;
    logic [4*DIGITS-1:0]       score_bcd;
    logic [7*DIGITS-1:0]       seg;
    logic                      score_pulse;
    logic                      saturated;
`ifdef BEST_SCORE_EN
    logic [4*DIGITS-1:0]       best_bcd;
    logic [7*DIGITS-1:0]       seg_best;

    modport master (
        output game_reset, enable, pillar_x, gap_y, bird_y,
        input  score_bcd, seg, score_pulse, saturated, best_bcd, seg_best
    );

    modport slave (
        input  game_reset, enable, pillar_x, gap_y, bird_y,
        output score_bcd, seg, score_pulse, saturated, best_bcd, seg_best
    );
`else
    modport master (
        output game_reset, enable, pillar_x, gap_y, bird_y,
        input  score_bcd, seg, score_pulse, saturated
    );

    modport slave (
        input  game_reset, enable, pillar_x, gap_y, bird_y,
        output score_bcd, seg, score_pulse, saturated
    );
`endif
endinterface

// File: rtl/pillar_pass_scorer.sv
// Pillar pass scorer: credits one point per pillar cleared inside its gap,
// keeps a DIGITS-wide saturating BCD score and drives active-low 7-seg codes.
// Optional feature macro: BEST_SCORE_EN (adds best_bcd / seg_best, kept
// across game resets and cleared only by reset_n).
module pillar_pass_scorer #(
    parameter int N_PILLARS = 3,
    parameter int DIGITS    = 2,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int PASS_X    = 14,
    parameter int GAP_H     = 36
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pillar_pass_scorer_if.slave  bus
);

    localparam logic [X_W-1:0] PASS_X_C = X_W'(PASS_X);
    localparam logic [Y_W:0]   GAP_H_C  = (Y_W + 1)'(GAP_H);

    // Active-low seven-segment code, bit 6 = a ... bit 0 = g; non-BCD blanks.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'b0000001;
            4'd1:    code = 7'b1001111;
            4'd2:    code = 7'b0010010;
            4'd3:    code = 7'b0000110;
            4'd4:    code = 7'b1001100;
            4'd5:    code = 7'b0100100;
            4'd6:    code = 7'b0100000;
            4'd7:    code = 7'b0001111;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0001100;
            default: code = 7'b1111111;
        endcase
        return code;
    endfunction

    // Ripple-carry BCD increment: a 9 wraps to 0 and carries, otherwise stop.
    function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        logic                carry;
        r     = v;
        carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (v[k*4 +: 4] == 4'd9) begin
                    r[k*4 +: 4] = 4'd0;
                end else begin
                    r[k*4 +: 4] = v[k*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[k*4 +: 4] = v[k*4 +: 4];
            end
        end
        return r;
    endfunction

    // True when every digit is 9, i.e. the score cannot advance any further.
    function automatic logic bcd_all_nine(input logic [4*DIGITS-1:0] v);
        logic all9;
        all9 = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[k*4 +: 4] != 4'd9) begin
                all9 = 1'b0;
            end else begin
                all9 = all9;
            end
        end
        return all9;
    endfunction

    logic [N_PILLARS-1:0]  at_pass_s;
    logic [N_PILLARS-1:0]  in_gap_s;
    logic [N_PILLARS-1:0]  detect_s;
    logic [N_PILLARS-1:0]  svc_s;
    logic                  svc_any_s;
    logic                  all_nine_s;
    logic [4*DIGITS-1:0]   score_inc_s;
    logic [7*DIGITS-1:0]   seg_s;

    logic [N_PILLARS-1:0]  pending_r;
    logic [N_PILLARS-1:0]  armed_r;
    logic [4*DIGITS-1:0]   score_r;
    logic                  pulse_r;
    logic                  saturated_r;

    // Per-channel compare; the gap test is widened by one bit so gap+GAP_H never wraps.
    for (genvar i = 0; i < N_PILLARS; i++) begin : g_chan
        logic [Y_W:0] gap_ext_s;
        logic [Y_W:0] bird_ext_s;
        assign gap_ext_s    = {1'b0, bus.gap_y[i*Y_W +: Y_W]};
        assign bird_ext_s   = {1'b0, bus.bird_y};
        assign at_pass_s[i] = (bus.pillar_x[i*X_W +: X_W] == PASS_X_C);
        assign in_gap_s[i]  = (gap_ext_s < bird_ext_s) &&
                              (bird_ext_s <= (gap_ext_s + GAP_H_C));
    end

    assign detect_s    = {N_PILLARS{bus.enable}} & armed_r & at_pass_s & in_gap_s;
    // Isolate the lowest set pending bit: lowest index is served first.
    assign svc_s       = pending_r & (~pending_r + N_PILLARS'(1));
    assign svc_any_s   = |pending_r;
    assign all_nine_s  = bcd_all_nine(score_r);
    assign score_inc_s = bcd_inc(score_r);

    // Score, pending queue, arming and saturation state.
    always_ff @(posedge clk) begin
        if (!reset_n || !bus.game_reset) begin
            score_r     <= {(4*DIGITS){1'b0}};
            pending_r   <= {N_PILLARS{1'b0}};
            armed_r     <= {N_PILLARS{1'b1}};
            pulse_r     <= 1'b0;
            saturated_r <= 1'b0;
        end else begin
            // Re-arm whenever the pillar is off the pass column, so a dwelling pillar scores once.
            armed_r   <= ~at_pass_s;
            pending_r <= (pending_r & ~svc_s) | detect_s;
            if (svc_any_s && all_nine_s) begin
                score_r     <= score_r;
                pulse_r     <= 1'b0;
                saturated_r <= 1'b1;
            end else if (svc_any_s) begin
                score_r     <= score_inc_s;
                pulse_r     <= 1'b1;
                saturated_r <= saturated_r;
            end else begin
                score_r     <= score_r;
                pulse_r     <= 1'b0;
                saturated_r <= saturated_r;
            end
        end
    end

    // Display decode of the live score, one code per digit.
    always_comb begin
        seg_s = {(7*DIGITS){1'b1}};
        for (int k = 0; k < DIGITS; k++) begin
            seg_s[k*7 +: 7] = seg_encode(score_r[k*4 +: 4]);
        end
    end

    assign bus.score_bcd   = score_r;
    assign bus.seg         = seg_s;
    assign bus.score_pulse = pulse_r;
    assign bus.saturated   = saturated_r;

`ifdef BEST_SCORE_EN
    logic [4*DIGITS-1:0] best_r;
    logic [7*DIGITS-1:0] seg_best_s;

    // Best score follows the live score whenever the live score is the record holder.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            best_r <= {(4*DIGITS){1'b0}};
        end else if (!bus.game_reset) begin
            best_r <= best_r;
        end else if (svc_any_s && !all_nine_s && (score_r == best_r)) begin
            best_r <= score_inc_s;
        end else begin
            best_r <= best_r;
        end
    end

    // Display decode of the best score.
    always_comb begin
        seg_best_s = {(7*DIGITS){1'b1}};
        for (int k = 0; k < DIGITS; k++) begin
            seg_best_s[k*7 +: 7] = seg_encode(best_r[k*4 +: 4]);
        end
    end

    assign bus.best_bcd = best_r;
    assign bus.seg_best = seg_best_s;
`else
`endif

endmodule
